// File: rtl/dvp_frame_source.sv
// DVP-style frame transmitter: vsync pulse, vertical blanking, then LINES lines of
// PIX_PER_LINE pixels, each preceded by HBLANK href-low cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for start; outputs low
//   S_VSYNC  | vsync high for VSYNC_LEN cycles (cyc counts down)
//   S_VBLANK | vsync/href low for VBLANK cycles (cyc counts down)
//   S_HBLANK | href low for HBLANK cycles before each line
//   S_ACTIVE | one pixel slot per cycle, col 0..PIX_PER_LINE-1
module dvp_frame_source #(
    parameter int PIX_PER_LINE = 21,
    parameter int LINES        = 3,
    parameter int HBLANK       = 2,
    parameter int VSYNC_LEN    = 1,
    parameter int VBLANK       = 1
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       px_valid,
    input  logic [7:0] px_data,
    output logic       px_ready,
    output logic       vsync,
    output logic       href,
    output logic [7:0] dout,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int CYC_MAX0 = (VSYNC_LEN > HBLANK) ? VSYNC_LEN : HBLANK;
    localparam int CYC_MAX  = (VBLANK > CYC_MAX0) ? VBLANK : CYC_MAX0;
    localparam int CW       = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int COLW     = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
    localparam int ROWW     = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [CW-1:0]   VSYNC_LD  = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0]   VBLANK_LD = CW'((VBLANK > 0) ? VBLANK - 1 : 0);
    localparam logic [CW-1:0]   HBLANK_LD = CW'(HBLANK - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(PIX_PER_LINE - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBLANK,
        S_HBLANK,
        S_ACTIVE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q, underrun_d;

    // busy_q is still high in the first IDLE cycle, so a start there is not
    // accepted; this guarantees two idle cycles between back-to-back frames.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        col_d      = col_q;
        row_d      = row_q;
        underrun_d = underrun_q;
        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = S_VSYNC;
                    cyc_d      = VSYNC_LD;
                    underrun_d = 1'b0;
                end
            end
            S_VSYNC: begin
                if (cyc_q == '0) begin
                    if (VBLANK > 0) begin
                        state_d = S_VBLANK;
                        cyc_d   = VBLANK_LD;
                    end else begin
                        state_d = S_HBLANK;
                        cyc_d   = HBLANK_LD;
                    end
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_VBLANK: begin
                if (cyc_q == '0) begin
                    state_d = S_HBLANK;
                    cyc_d   = HBLANK_LD;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_HBLANK: begin
                if (cyc_q == '0) begin
                    state_d = S_ACTIVE;
                    col_d   = '0;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!px_valid) underrun_d = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        state_d = S_HBLANK;
                        row_d   = row_q + 1'b1;
                        cyc_d   = HBLANK_LD;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vsync_d      = (state_q == S_VSYNC);
        href_d       = (state_q == S_ACTIVE);
        dout_d       = (state_q == S_ACTIVE && px_valid) ? px_data : 8'h00;
        busy_d       = (state_q != S_IDLE);
        frame_done_d = (state_q == S_IDLE) && busy_q;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            dout_q       <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign px_ready   = (state_q == S_ACTIVE);
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dvp_frame_source.sv
// Directed bench for dvp_frame_source: default-timing frames, underrun, mid-frame
// start, async reset, minimal geometry and back-to-back frames.
module tb_dvp_frame_source;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       rst_n;
    logic       start, px_valid, px_ready, vsync, href, busy, frame_done, underrun;
    logic [7:0] px_data, dout;
    logic       start2, px_ready2, vsync2, href2, busy2, frame_done2, underrun2;
    logic [7:0] dout2;

    int k = 0;
    int bad_k = -1;
    int tests_run = 0;
    int tests_failed = 0;

    assign px_valid = (k != bad_k);
    assign px_data  = 8'((k % 21) + (k / 21) + 1);

    // slot index tracked from the observed href stream, restarted by vsync
    always @(negedge pclk) begin
        if (vsync) k <= 0;
        else if (href) k <= k + 1;
    end

    dvp_frame_source dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .px_valid(px_valid), .px_data(px_data),
        .px_ready(px_ready), .vsync(vsync), .href(href), .dout(dout), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    dvp_frame_source #(
        .PIX_PER_LINE(1), .LINES(1), .HBLANK(1), .VSYNC_LEN(1), .VBLANK(0)
    ) dut_min (
        .pclk(pclk), .rst_n(rst_n), .start(start2), .px_valid(1'b1), .px_data(8'hA5),
        .px_ready(px_ready2), .vsync(vsync2), .href(href2), .dout(dout2), .busy(busy2),
        .frame_done(frame_done2), .underrun(underrun2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] obs1();
        return {px_ready, vsync, href, busy, frame_done, underrun, dout};
    endfunction

    function automatic logic [13:0] obs2();
        return {px_ready2, vsync2, href2, busy2, frame_done2, underrun2, dout2};
    endfunction

    // default geometry: i=0 is the cycle after start is sampled
    function automatic int slot_of(int i);
        int t;
        if (i < 3) return -1;
        t = i - 3;
        if (t / 23 >= 3) return -1;
        if (t % 23 < 2) return -1;
        return (t / 23) * 21 + (t % 23) - 2;
    endfunction

    function automatic logic [13:0] exp_def(int i, int bad);
        int s;
        int i_bad;
        logic [7:0] d;
        logic ur;
        s     = slot_of(i);
        i_bad = 3 + (bad / 21) * 23 + 2 + (bad % 21);
        d     = (s < 0 || s == bad) ? 8'h00 : 8'((s % 21) + (s / 21) + 1);
        ur    = (bad >= 0) && (i >= i_bad);
        return {slot_of(i + 1) >= 0, i == 1, s >= 0, (i >= 1 && i <= 71), i == 72, ur, d};
    endfunction

    task automatic run_frame(input string name, input int bad, input int restart_at);
        bad_k = bad;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        for (int i = 0; i < 74; i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(obs1()), 32'(exp_def(i, bad)));
            start = (i == restart_at);
            @(negedge pclk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [13:0] e2 [5];
        int overlap, rises, idle_run, fv, last_href, quiet;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        #12;
        check("reset_main", 32'(obs1()), 32'h0);
        check("reset_min", 32'(obs2()), 32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        check("idle_main", 32'(obs1()), 32'h0);

        run_frame("normal", -1, -1);
        run_frame("underrun", 4, -1);
        check("underrun_sticky", 32'(underrun), 32'h1);
        run_frame("restart_ignored", -1, 30);

        // async reset during line 2, pixel 10
        bad_k = -1;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        repeat (38) @(negedge pclk);
        check("rst_pre_href", 32'({href, dout}), 32'({1'b1, 8'd12}));
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(obs1()), 32'h0);
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (10) begin
            @(negedge pclk);
            if (vsync || href || busy) quiet++;
        end
        check("rst_stays_idle", 32'(quiet), 32'h0);
        run_frame("after_reset", -1, -1);

        // minimal geometry on the second instance
        e2[0] = 14'h0000;
        e2[1] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        e2[2] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        e2[3] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        e2[4] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        start2 = 1'b1;
        @(negedge pclk);
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("min[%0d]", i), 32'(obs2()), 32'(e2[i]));
            @(negedge pclk);
        end

        // start held high: back-to-back frames
        overlap   = 0;
        rises     = 0;
        idle_run  = 0;
        fv        = 0;
        last_href = 0;
        start = 1'b1;
        for (int c = 0; c < 250; c++) begin
            @(negedge pclk);
            if (vsync && href) overlap++;
            if (!busy) idle_run++;
            if (href) last_href = c;
            if (vsync && c != fv + 1 || vsync && rises == 0) begin
                if (rises > 0) begin
                    check($sformatf("b2b_len%0d", rises), 32'(last_href - fv + 1), 32'd71);
                    check($sformatf("b2b_gap%0d", rises), 32'(idle_run >= 2), 32'h1);
                end
                rises++;
                fv = c;
                idle_run = 0;
            end
        end
        start = 1'b0;
        check("b2b_frames", 32'(rises >= 3), 32'h1);
        check("b2b_overlap", 32'(overlap), 32'h0);
        quiet = 0;
        while (busy && quiet < 100) begin
            @(negedge pclk);
            quiet++;
        end
        check("b2b_drain", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
